axi_sram_slave: RTL and testbench

//  AXI-lite style single-beat slave responder: accepts AW/W and AR requests from the interconnect, executes them on one sync SRAM macro,

---
 rtl/axi_sram_slave_pkg.sv | 20 ++
 rtl/axi_sram_slave_arb.sv | 33 +++
 rtl/axi_sram_slave.sv | 159 +++++++++++++++
 tb/tb_axi_sram_slave.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared types for the AXI-lite single-beat SRAM responder.
// Holds the FSM state encoding, the write/read priority token and the response code.
package axi_sram_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_RESP = 3'd4
    } state_e;

    typedef enum logic {
        PRIO_WRITE = 1'b0,
        PRIO_READ  = 1'b1
    } prio_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_sram_slave_arb.sv
// Two-way rotating grant between a pending write address and a pending read address.
// The priority token flips to the other side after every grant.
module axi_sram_slave_arb
    import axi_sram_slave_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_req_wr,
    input  logic i_req_rd,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);

    prio_e r_prio;

    // A request is only ever granted while its valid is high, so a grant is also the handshake.
    always_comb begin
        o_gnt_wr = i_enable && i_req_wr && (!i_req_rd || (r_prio == PRIO_WRITE));
        o_gnt_rd = i_enable && i_req_rd && (!i_req_wr || (r_prio == PRIO_READ));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prio <= PRIO_WRITE;
        end else if (o_gnt_wr) begin
            r_prio <= PRIO_READ;
        end else if (o_gnt_rd) begin
            r_prio <= PRIO_WRITE;
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI-lite single-beat slave that executes one write or read at a time on a sync SRAM macro.
// state      | meaning
// ST_IDLE    | waiting for AW or AR; arbiter picks one when both are valid
// ST_WR_DATA | AW taken, waiting for the W beat; SRAM written in the W handshake cycle
// ST_WR_RESP | BVALID held until BREADY
// ST_RD_WAIT | SRAM read issued last cycle, capture DO at the end of this cycle
// ST_RD_RESP | RVALID held until RREADY
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     AWID_S,
    input  logic [31:0]             AWADDR_S,
    input  logic                    AWVALID_S,
    output logic                    AWREADY_S,
    input  logic [DATA_WIDTH-1:0]   WDATA_S,
    input  logic [DATA_WIDTH/8-1:0] WSTRB_S,
    input  logic                    WVALID_S,
    output logic                    WREADY_S,
    output logic [ID_WIDTH-1:0]     BID_S,
    output logic [1:0]              BRESP_S,
    output logic                    BVALID_S,
    input  logic                    BREADY_S,
    input  logic [ID_WIDTH-1:0]     ARID_S,
    input  logic [31:0]             ARADDR_S,
    input  logic                    ARVALID_S,
    output logic                    ARREADY_S,
    output logic [ID_WIDTH-1:0]     RID_S,
    output logic [DATA_WIDTH-1:0]   RDATA_S,
    output logic [1:0]              RRESP_S,
    output logic                    RVALID_S,
    input  logic                    RREADY_S,
    output logic                    CEB,
    output logic [DATA_WIDTH/8-1:0] WEB,
    output logic [MEM_AW-1:0]       A,
    output logic [DATA_WIDTH-1:0]   DI,
    input  logic [DATA_WIDTH-1:0]   DO
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [MEM_AW-1:0]     r_waddr;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_idle;
    logic                  w_aw_hs;
    logic                  w_ar_hs;
    logic                  w_w_hs;
    logic [MEM_AW-1:0]     w_aw_word;
    logic [MEM_AW-1:0]     w_ar_word;
    logic                  w_unused;

    // Byte lane and high address bits are dropped, so addresses alias modulo the macro size.
    assign w_aw_word = AWADDR_S[MEM_AW+1:2];
    assign w_ar_word = ARADDR_S[MEM_AW+1:2];
    assign w_unused  = ^{AWADDR_S[31:MEM_AW+2], AWADDR_S[1:0],
                         ARADDR_S[31:MEM_AW+2], ARADDR_S[1:0]};

    // Every handshake is qualified by rst so nothing is accepted or written during a reset cycle.
    assign w_idle = rst && (r_state == ST_IDLE);
    assign w_w_hs = rst && (r_state == ST_WR_DATA) && WVALID_S;

    axi_sram_slave_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_enable (w_idle),
        .i_req_wr (AWVALID_S),
        .i_req_rd (ARVALID_S),
        .o_gnt_wr (w_aw_hs),
        .o_gnt_rd (w_ar_hs)
    );

    assign AWREADY_S = w_aw_hs;
    assign ARREADY_S = w_ar_hs;
    assign WREADY_S  = rst && (r_state == ST_WR_DATA);
    assign BVALID_S  = rst && (r_state == ST_WR_RESP);
    assign RVALID_S  = rst && (r_state == ST_RD_RESP);
    assign BID_S     = r_bid;
    assign RID_S     = r_rid;
    assign RDATA_S   = r_rdata;
    assign BRESP_S   = RESP_OKAY;
    assign RRESP_S   = RESP_OKAY;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_bid   <= '0;
            r_rid   <= '0;
            r_waddr <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_aw_hs) begin
                r_bid   <= AWID_S;
                r_waddr <= w_aw_word;
            end
            if (w_ar_hs) begin
                r_rid <= ARID_S;
            end
            if (r_state == ST_RD_WAIT) begin
                r_rdata <= DO;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        CEB         = 1'b1;
        WEB         = {STRB_W{1'b1}};
        A           = '0;
        DI          = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_aw_hs) begin
                    w_state_nxt = ST_WR_DATA;
                end else if (w_ar_hs) begin
                    w_state_nxt = ST_RD_WAIT;
                    CEB         = 1'b0;
                    A           = w_ar_word;
                end
            end
            ST_WR_DATA: begin
                if (w_w_hs) begin
                    w_state_nxt = ST_WR_RESP;
                    CEB         = 1'b0;
                    WEB         = ~WSTRB_S;
                    A           = r_waddr;
                    DI          = WDATA_S;
                end
            end
            ST_WR_RESP: begin
                if (BREADY_S) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                w_state_nxt = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (RREADY_S) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural sync SRAM behind it.
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
module tb_axi_sram_slave;

    logic        clk;
    logic        rst;
    logic [7:0]  AWID_S;
    logic [31:0] AWADDR_S;
    logic        AWVALID_S;
    logic        AWREADY_S;
    logic [31:0] WDATA_S;
    logic [3:0]  WSTRB_S;
    logic        WVALID_S;
    logic        WREADY_S;
    logic [7:0]  BID_S;
    logic [1:0]  BRESP_S;
    logic        BVALID_S;
    logic        BREADY_S;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RVALID_S;
    logic        RREADY_S;
    logic        CEB;
    logic [3:0]  WEB;
    logic [13:0] A;
    logic [31:0] DI;
    logic [31:0] DO;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;

    logic [31:0] mem [0:16383];

    axi_sram_slave #(.ID_WIDTH(8), .DATA_WIDTH(32), .MEM_AW(14)) dut (
        .clk(clk), .rst(rst),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (CEB === 1'b0) begin
            if (WEB === 4'hF) begin
                DO <= mem[A];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (!WEB[b]) mem[A][b*8 +: 8] <= DI[b*8 +: 8];
                end
                wr_count++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        AWID_S = '0; AWADDR_S = '0; AWVALID_S = 0;
        WDATA_S = '0; WSTRB_S = '0; WVALID_S = 0; BREADY_S = 0;
        ARID_S = '0; ARADDR_S = '0; ARVALID_S = 0; RREADY_S = 0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [7:0] id,
                             input logic [31:0] data, input logic [3:0] strb,
                             output logic ok, output logic [7:0] bid, output logic [1:0] bresp,
                             output logic [3:0] web_seen, output logic [13:0] a_seen,
                             output logic [31:0] di_seen, output int b_lat);
        int n;
        ok = 1'b1;
        @(negedge clk);
        AWADDR_S = addr; AWID_S = id; AWVALID_S = 1;
        n = 0; #1;
        while (AWREADY_S !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        if (AWREADY_S !== 1'b1) ok = 1'b0;
        @(posedge clk); @(negedge clk);
        AWVALID_S = 0; WDATA_S = data; WSTRB_S = strb; WVALID_S = 1;
        n = 0; #1;
        while (WREADY_S !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        if (WREADY_S !== 1'b1) ok = 1'b0;
        web_seen = WEB; a_seen = A; di_seen = DI;
        @(posedge clk); @(negedge clk);
        WVALID_S = 0; BREADY_S = 1;
        b_lat = 0; #1;
        while (BVALID_S !== 1'b1 && b_lat < 20) begin @(negedge clk); #1; b_lat++; end
        if (BVALID_S !== 1'b1) ok = 1'b0;
        bid = BID_S; bresp = BRESP_S;
        @(posedge clk); @(negedge clk);
        BREADY_S = 0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [7:0] id,
                            output logic ok, output logic [31:0] rdata, output logic [7:0] rid,
                            output logic [1:0] rresp, output int lat, output logic [13:0] a_seen);
        int n;
        ok = 1'b1;
        @(negedge clk);
        ARADDR_S = addr; ARID_S = id; ARVALID_S = 1;
        n = 0; #1;
        while (ARREADY_S !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        if (ARREADY_S !== 1'b1) ok = 1'b0;
        a_seen = A;
        @(posedge clk); @(negedge clk);
        ARVALID_S = 0; RREADY_S = 1;
        lat = 1; #1;
        while (RVALID_S !== 1'b1 && lat < 20) begin @(negedge clk); #1; lat++; end
        if (RVALID_S !== 1'b1) ok = 1'b0;
        rdata = RDATA_S; rid = RID_S; rresp = RRESP_S;
        @(posedge clk); @(negedge clk);
        RREADY_S = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        AWVALID_S = 1; ARVALID_S = 1; WVALID_S = 1; WSTRB_S = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({AWREADY_S, ARREADY_S, WREADY_S, BVALID_S, RVALID_S} !== 5'b0) begin
            failures++;
            $display("FAIL reset_handshakes got=%b exp=00000", {AWREADY_S, ARREADY_S, WREADY_S, BVALID_S, RVALID_S});
        end
        checks++;
        if ({CEB, WEB, A, DI} !== {1'b1, 4'hF, 14'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_sram got CEB=%b WEB=%h A=%h DI=%h exp 1/f/0/0", CEB, WEB, A, DI);
        end
        checks++;
        if ({BID_S, RID_S, RDATA_S, BRESP_S, RRESP_S} !== 52'h0) begin
            failures++;
            $display("FAIL reset_resp got BID=%h RID=%h RDATA=%h exp 0", BID_S, RID_S, RDATA_S);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_write_read();
        logic ok; logic [7:0] id; logic [1:0] resp; logic [3:0] web; logic [13:0] a;
        logic [31:0] di, rd; int lat;
        bus_write(32'h10, 8'h3C, 32'hDEADBEEF, 4'hF, ok, id, resp, web, a, di, lat);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wr_timeout got=%b exp=1", ok); end
        checks++; if (a !== 14'd4) begin failures++; $display("FAIL wr_addr got=%h exp=4", a); end
        checks++; if ({web, di} !== {4'h0, 32'hDEADBEEF}) begin failures++; $display("FAIL wr_sram got WEB=%h DI=%h exp 0/deadbeef", web, di); end
        checks++; if (lat !== 0) begin failures++; $display("FAIL b_latency got=%0d exp=0", lat); end
        checks++; if ({id, resp} !== {8'h3C, 2'b00}) begin failures++; $display("FAIL bid_bresp got=%h/%b exp 3c/00", id, resp); end
        bus_read(32'h10, 8'h71, ok, rd, id, resp, lat, a);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rd_timeout got=%b exp=1", ok); end
        checks++; if (a !== 14'd4) begin failures++; $display("FAIL rd_addr got=%h exp=4", a); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL r_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rdata got=%h exp=deadbeef", rd); end
        checks++; if ({id, resp} !== {8'h71, 2'b00}) begin failures++; $display("FAIL rid_rresp got=%h/%b exp 71/00", id, resp); end
    endtask

    task automatic test_strobe();
        logic ok; logic [7:0] id; logic [1:0] resp; logic [3:0] web; logic [13:0] a;
        logic [31:0] di, rd; int lat;
        bus_write(32'h10, 8'h01, 32'h0000AB00, 4'b0010, ok, id, resp, web, a, di, lat);
        checks++; if (web !== 4'b1101) begin failures++; $display("FAIL strobe_web got=%b exp=1101", web); end
        bus_read(32'h10, 8'h02, ok, rd, id, resp, lat, a);
        checks++; if (rd !== 32'hDEADABEF) begin failures++; $display("FAIL strobe_readback got=%h exp=deadabef", rd); end
    endtask

    task automatic test_alias();
        logic ok; logic [7:0] id; logic [1:0] resp; logic [3:0] web; logic [13:0] a;
        logic [31:0] di, rd; int lat;
        bus_write(32'h0001_0010, 8'h09, 32'hCAFEF00D, 4'hF, ok, id, resp, web, a, di, lat);
        checks++; if (a !== 14'd4) begin failures++; $display("FAIL alias_wr_addr got=%h exp=4", a); end
        bus_read(32'h13, 8'h0A, ok, rd, id, resp, lat, a);
        checks++; if (a !== 14'd4) begin failures++; $display("FAIL alias_rd_addr got=%h exp=4", a); end
        checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL alias_readback got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_fairness();
        logic g [0:9];
        int ng, cyc;
        logic both;
        @(negedge clk); rst = 0; idle_inputs();
        @(negedge clk); rst = 1;
        AWVALID_S = 1; ARVALID_S = 1; WVALID_S = 1; WSTRB_S = 4'h0;
        BREADY_S = 1; RREADY_S = 1; AWADDR_S = 32'h80; ARADDR_S = 32'h80;
        ng = 0; cyc = 0; both = 0;
        while (ng < 10 && cyc < 200) begin
            #1;
            if (AWREADY_S === 1'b1 && ARREADY_S === 1'b1) both = 1;
            if (AWREADY_S === 1'b1) begin g[ng] = 1'b0; ng++; end
            else if (ARREADY_S === 1'b1) begin g[ng] = 1'b1; ng++; end
            @(negedge clk);
            cyc++;
        end
        AWVALID_S = 0; ARVALID_S = 0; WVALID_S = 0;
        repeat (5) @(negedge clk);
        idle_inputs();
        checks++; if (ng !== 10) begin failures++; $display("FAIL fair_grant_count got=%0d exp=10", ng); end
        checks++; if (both !== 1'b0) begin failures++; $display("FAIL fair_both_ready got=%b exp=0", both); end
        for (int i = 0; i < ng; i++) begin
            checks++;
            if (g[i] !== 1'(i % 2)) begin
                failures++;
                $display("FAIL fair_grant_%0d got=%s exp=%s", i, g[i] ? "read" : "write", (i % 2) ? "read" : "write");
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        AWADDR_S = 32'h40; AWID_S = 8'h5A; AWVALID_S = 1; #1;
        checks++; if (AWREADY_S !== 1'b1) begin failures++; $display("FAIL bp_awready got=%b exp=1", AWREADY_S); end
        @(negedge clk);
        AWVALID_S = 0; WDATA_S = 32'h12345678; WSTRB_S = 4'hF; WVALID_S = 1;
        @(negedge clk);
        WVALID_S = 0; AWVALID_S = 1; ARVALID_S = 1; ARADDR_S = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({BVALID_S, BID_S, AWREADY_S, ARREADY_S} !== {1'b1, 8'h5A, 2'b00}) begin
                failures++;
                $display("FAIL bp_b_hold_%0d got BVALID=%b BID=%h AWREADY=%b ARREADY=%b exp 1/5a/0/0", i, BVALID_S, BID_S, AWREADY_S, ARREADY_S);
            end
            @(negedge clk);
        end
        AWVALID_S = 0; ARVALID_S = 0; BREADY_S = 1;
        @(negedge clk);
        BREADY_S = 0; #1;
        checks++; if (BVALID_S !== 1'b0) begin failures++; $display("FAIL bp_b_release got=%b exp=0", BVALID_S); end
        @(negedge clk);
        ARADDR_S = 32'h40; ARID_S = 8'hC3; ARVALID_S = 1; #1;
        checks++; if (ARREADY_S !== 1'b1) begin failures++; $display("FAIL bp_arready got=%b exp=1", ARREADY_S); end
        @(negedge clk);
        ARVALID_S = 0;
        @(negedge clk);
        AWVALID_S = 1; ARVALID_S = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({RVALID_S, RID_S, RDATA_S, AWREADY_S, ARREADY_S} !== {1'b1, 8'hC3, 32'h12345678, 2'b00}) begin
                failures++;
                $display("FAIL bp_r_hold_%0d got RVALID=%b RID=%h RDATA=%h AWREADY=%b ARREADY=%b exp 1/c3/12345678/0/0", i, RVALID_S, RID_S, RDATA_S, AWREADY_S, ARREADY_S);
            end
            @(negedge clk);
        end
        AWVALID_S = 0; ARVALID_S = 0; RREADY_S = 1;
        @(negedge clk);
        RREADY_S = 0; #1;
        checks++; if (RVALID_S !== 1'b0) begin failures++; $display("FAIL bp_r_release got=%b exp=0", RVALID_S); end
    endtask

    task automatic test_reset_mid();
        logic ok; logic [7:0] id; logic [1:0] resp; logic [3:0] web; logic [13:0] a;
        logic [31:0] di, rd; int lat, wr_before;
        bus_write(32'h20, 8'h44, 32'h11223344, 4'hF, ok, id, resp, web, a, di, lat);
        wr_before = wr_count;
        @(negedge clk);
        AWADDR_S = 32'h20; AWID_S = 8'h77; AWVALID_S = 1; #1;
        checks++; if (AWREADY_S !== 1'b1) begin failures++; $display("FAIL rstmid_aw got=%b exp=1", AWREADY_S); end
        @(negedge clk);
        AWVALID_S = 0; rst = 0;
        WDATA_S = 32'hFFFFFFFF; WSTRB_S = 4'hF; WVALID_S = 1; #1;
        checks++; if ({WREADY_S, CEB} !== 2'b01) begin failures++; $display("FAIL rstmid_gate got WREADY=%b CEB=%b exp 0/1", WREADY_S, CEB); end
        @(negedge clk); #1;
        checks++;
        if ({AWREADY_S, ARREADY_S, WREADY_S, BVALID_S, RVALID_S, CEB, WEB, A, DI, BID_S}
            !== {5'b0, 1'b1, 4'hF, 14'h0, 32'h0, 8'h0}) begin
            failures++;
            $display("FAIL rstmid_outputs got rdy/vld=%b CEB=%b WEB=%h A=%h DI=%h BID=%h exp 00000/1/f/0/0/0",
                     {AWREADY_S, ARREADY_S, WREADY_S, BVALID_S, RVALID_S}, CEB, WEB, A, DI, BID_S);
        end
        @(negedge clk);
        rst = 1; WVALID_S = 0; BREADY_S = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (BVALID_S !== 1'b0) begin failures++; $display("FAIL rstmid_no_b got=%b exp=0", BVALID_S); end
        BREADY_S = 0;
        checks++; if (wr_count !== wr_before) begin failures++; $display("FAIL rstmid_sram_writes got=%0d exp=%0d", wr_count, wr_before); end
        bus_read(32'h20, 8'h12, ok, rd, id, resp, lat, a);
        checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL rstmid_readback got=%h exp=11223344", rd); end
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_strobe();
        test_alias();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
